// File: rtl/systolic_array_sequencer_pkg.sv
// Shared types for the systolic array tile sequencer: the Scalar lane element,
// value width, and the sequencer state encoding.
`ifndef SYS_ARRAY_LEN
`define SYS_ARRAY_LEN 4
`endif

package systolic_array_sequencer_pkg;

  // Array side, shared with the systolic array itself.
  localparam int ARRAY_N = `SYS_ARRAY_LEN;

  // Width of one operand value carried on a lane.
  localparam int VALUE_W = 16;

  typedef logic [VALUE_W-1:0] value_t;

  // One lane element: the array only consumes value when valid is set.
  typedef struct packed {
    logic   valid;
    value_t value;
  } scalar_t;

  localparam scalar_t SCALAR_ZERO = '0;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    CLEAR = 3'd1,
    FEED  = 3'd2,
    DRAIN = 3'd3,
    DONE  = 3'd4
  } seq_state_e;

  // Build a valid lane element from a raw operand.
  function automatic scalar_t make_scalar(input value_t v);
    scalar_t s;
    s.valid = 1'b1;
    s.value = v;
    return s;
  endfunction

endpackage

// File: rtl/systolic_array_sequencer_skew.sv
// Fixed-depth Scalar delay line used to skew one array lane.
// DEPTH=0 is a plain wire; otherwise DEPTH register stages cleared on rst.
module skew_delay_line
  import systolic_array_sequencer_pkg::*;
#(
  parameter int DEPTH = 0
) (
  input  logic    clk,
  input  logic    rst,
  input  scalar_t din,
  output scalar_t dout
);

  if (DEPTH == 0) begin : g_wire
    // Clock and reset have no load on a zero-depth lane.
    logic unused_ctrl;
    assign unused_ctrl = clk ^ rst;
    assign dout = din;
  end else begin : g_shift
    scalar_t stage [DEPTH];

    // Shift one element per cycle; stage 0 takes the lane input.
    always_ff @(posedge clk) begin
      if (rst) begin
        for (int i = 0; i < DEPTH; i++) begin
          stage[i] <= SCALAR_ZERO;
        end
      end else begin
        stage[0] <= din;
        for (int i = 1; i < DEPTH; i++) begin
          stage[i] <= stage[i-1];
        end
      end
    end

    assign dout = stage[DEPTH-1];
  end

endmodule

// File: rtl/systolic_array_sequencer.sv
// Tile controller for the NxN systolic MAC array.
// Takes one job (start + k_len), optionally clears the accumulators, streams
// k_len (A column, B row) slices into the array with per-lane skew, waits for
// the array to drain, then pulses done.
//
// Slice handshake: a slice is transferred on a rising edge where slice_valid
// and slice_ready are both high. slice_ready is high only in FEED and does not
// depend on slice_valid; slice_valid outside FEED is never consumed.
module systolic_array_sequencer
  import systolic_array_sequencer_pkg::*;
#(
  parameter int N     = `SYS_ARRAY_LEN,
  parameter int K_MAX = 256,
  parameter int K_W   = $clog2(K_MAX + 1)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [K_W-1:0]    k_len,
  input  logic              accumulate,
  output logic              busy,
  input  logic              slice_valid,
  output logic              slice_ready,
  input  value_t [N-1:0]    slice_a,
  input  value_t [N-1:0]    slice_b,
  output logic              arr_clear,
  output scalar_t [N-1:0]   arr_row,
  output scalar_t [N-1:0]   arr_column,
  input  logic              arr_ready,
  output logic              done,
  output seq_state_e        state
);

  // Drain must outlast the skew flush plus the array's registered ready flag.
  localparam int                 DRAIN_W   = $clog2(N + 3);
  localparam logic [DRAIN_W-1:0] DRAIN_MIN = DRAIN_W'(N + 2);
  localparam logic [DRAIN_W-1:0] DRAIN_ONE = DRAIN_W'(1);
  localparam logic [K_W-1:0]     K_MAX_V   = K_W'(K_MAX);
  localparam logic [K_W-1:0]     K_ONE     = K_W'(1);

  seq_state_e         state_q;
  seq_state_e         state_d;
  logic [K_W-1:0]     k_len_q;
  logic [K_W-1:0]     k_cnt_q;
  logic [DRAIN_W-1:0] drain_cnt_q;
  logic [K_W-1:0]     k_eff;
  logic               accept;
  logic               last_accept;

  scalar_t [N-1:0]    row_in_q;
  scalar_t [N-1:0]    col_in_q;

  // Oversized jobs are clamped to the largest supported tile depth.
  assign k_eff = (k_len > K_MAX_V) ? K_MAX_V : k_len;

  assign accept      = slice_valid && slice_ready;
  assign last_accept = accept && ((k_cnt_q + K_ONE) == k_len_q);

  // Moore outputs decoded from the state register.
  assign busy        = (state_q != IDLE);
  assign slice_ready = (state_q == FEED);
  assign arr_clear   = (state_q == CLEAR);
  assign done        = (state_q == DONE);
  assign state       = state_q;

  // Next-state logic for the job sequence IDLE-CLEAR-FEED-DRAIN-DONE.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: begin
        if (start) begin
          if (!accumulate)        state_d = CLEAR;
          else if (k_eff == '0)   state_d = DRAIN;
          else                    state_d = FEED;
        end
      end
      CLEAR: begin
        state_d = (k_len_q == '0) ? DRAIN : FEED;
      end
      FEED: begin
        if (last_accept) state_d = DRAIN;
      end
      DRAIN: begin
        if ((drain_cnt_q >= DRAIN_MIN) && arr_ready) state_d = DONE;
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State register, job capture and the slice / drain counters.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      k_len_q     <= '0;
      k_cnt_q     <= '0;
      drain_cnt_q <= '0;
    end else begin
      state_q <= state_d;

      if ((state_q == IDLE) && start) begin
        k_len_q <= k_eff;
      end

      if (state_q == IDLE) begin
        k_cnt_q <= '0;
      end else if (accept) begin
        k_cnt_q <= k_cnt_q + K_ONE;
      end

      // Saturates at the minimum drain length, so it can never wrap.
      if (state_q != DRAIN) begin
        drain_cnt_q <= '0;
      end else if (drain_cnt_q < DRAIN_MIN) begin
        drain_cnt_q <= drain_cnt_q + DRAIN_ONE;
      end
    end
  end

  // Lane input register: accepted slice data, otherwise an invalid bubble.
  always_ff @(posedge clk) begin
    if (rst) begin
      row_in_q <= '0;
      col_in_q <= '0;
    end else begin
      for (int i = 0; i < N; i++) begin
        row_in_q[i] <= accept ? make_scalar(slice_a[i]) : SCALAR_ZERO;
        col_in_q[i] <= accept ? make_scalar(slice_b[i]) : SCALAR_ZERO;
      end
    end
  end

  // Lane i is delayed i further cycles so slice k meets itself at every PE.
  for (genvar i = 0; i < N; i++) begin : g_lane
    skew_delay_line #(.DEPTH(i)) u_row_skew (
      .clk  (clk),
      .rst  (rst),
      .din  (row_in_q[i]),
      .dout (arr_row[i])
    );

    skew_delay_line #(.DEPTH(i)) u_col_skew (
      .clk  (clk),
      .rst  (rst),
      .din  (col_in_q[i]),
      .dout (arr_column[i])
    );
  end

endmodule

// File: tb/tb_systolic_array_sequencer.sv
// Directed bench for systolic_array_sequencer with a small behavioural
// 4x4 output-stationary systolic array attached to the arr_* ports.
module tb_systolic_array_sequencer;
  import systolic_array_sequencer_pkg::*;

  localparam int N     = 4;
  localparam int K_MAX = 256;
  localparam int K_W   = 9;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic            start = 1'b0;
  logic [K_W-1:0]  k_len = '0;
  logic            accumulate = 1'b0;
  logic            busy;
  logic            slice_valid = 1'b0;
  logic            slice_ready;
  value_t [N-1:0]  slice_a = '0;
  value_t [N-1:0]  slice_b = '0;
  logic            arr_clear;
  scalar_t [N-1:0] arr_row;
  scalar_t [N-1:0] arr_column;
  logic            arr_ready;
  logic            done;
  seq_state_e      state;

  systolic_array_sequencer #(.N(N), .K_MAX(K_MAX), .K_W(K_W)) dut (
    .clk         (clk),
    .rst         (rst),
    .start       (start),
    .k_len       (k_len),
    .accumulate  (accumulate),
    .busy        (busy),
    .slice_valid (slice_valid),
    .slice_ready (slice_ready),
    .slice_a     (slice_a),
    .slice_b     (slice_b),
    .arr_clear   (arr_clear),
    .arr_row     (arr_row),
    .arr_column  (arr_column),
    .arr_ready   (arr_ready),
    .done        (done),
    .state       (state)
  );

  // ---------------- systolic array model ----------------
  // Rows flow right, columns flow down, one register per PE; MAC on valid pair.
  scalar_t row_r [N][N];
  scalar_t col_r [N][N];
  int      acc   [N][N];
  logic    all_idle;

  always_comb begin
    all_idle = 1'b1;
    for (int v = 0; v < N; v++) begin
      if (arr_row[v].valid || arr_column[v].valid) all_idle = 1'b0;
      for (int h = 0; h < N; h++) begin
        if (row_r[v][h].valid || col_r[v][h].valid) all_idle = 1'b0;
      end
    end
  end

  always @(posedge clk) begin
    if (rst) begin
      for (int v = 0; v < N; v++) begin
        for (int h = 0; h < N; h++) begin
          row_r[v][h] <= SCALAR_ZERO;
          col_r[v][h] <= SCALAR_ZERO;
          acc[v][h]   <= 0;
        end
      end
      arr_ready <= 1'b1;
    end else begin
      for (int v = 0; v < N; v++) begin
        row_r[v][0] <= arr_row[v];
        col_r[0][v] <= arr_column[v];
        for (int h = 1; h < N; h++) begin
          row_r[v][h] <= row_r[v][h-1];
          col_r[h][v] <= col_r[h-1][v];
        end
        for (int h = 0; h < N; h++) begin
          if (arr_clear) acc[v][h] <= 0;
          else if (row_r[v][h].valid && col_r[v][h].valid)
            acc[v][h] <= acc[v][h] + int'(row_r[v][h].value) * int'(col_r[v][h].value);
        end
      end
      arr_ready <= all_idle;
    end
  end

  // ---------------- scoreboard ----------------
  int n_vec = 0;
  int n_err = 0;

  task automatic check(input string tag, input longint got, input longint exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  int a_sl [16][N];
  int b_sl [16][N];
  int exp_m [N][N];

  task automatic set_identity();
    for (int k = 0; k < 16; k++)
      for (int i = 0; i < N; i++) begin
        a_sl[k][i] = (i == k) ? 1 : 0;
        b_sl[k][i] = (i == k) ? 1 : 0;
      end
    for (int v = 0; v < N; v++)
      for (int h = 0; h < N; h++) exp_m[v][h] = (v == h) ? 1 : 0;
  endtask

  // A column k = all (k+1), B row k lane i = i+1; over 3 slices C[v][h] = 6*(h+1).
  task automatic set_ramp();
    for (int k = 0; k < 16; k++)
      for (int i = 0; i < N; i++) begin
        a_sl[k][i] = k + 1;
        b_sl[k][i] = i + 1;
      end
    for (int v = 0; v < N; v++)
      for (int h = 0; h < N; h++) exp_m[v][h] = 6 * (h + 1);
  endtask

  task automatic set_ones(input int expv);
    for (int k = 0; k < 16; k++)
      for (int i = 0; i < N; i++) begin
        a_sl[k][i] = 1;
        b_sl[k][i] = 1;
      end
    for (int v = 0; v < N; v++)
      for (int h = 0; h < N; h++) exp_m[v][h] = expv;
  endtask

  task automatic check_matrix(input string tag);
    for (int v = 0; v < N; v++)
      for (int h = 0; h < N; h++)
        check($sformatf("%s[%0d][%0d]", tag, v, h), acc[v][h], exp_m[v][h]);
  endtask

  // ---------------- driver ----------------
  int j_accepts, j_clears, j_first_clear, j_dones, j_ready_cyc, j_drain_cyc;
  int j_l0_valid, j_l0_first, j_l3_first;

  // Entered and left on a falling edge. stall_mask bit f drops slice_valid on
  // the f-th FEED cycle; noise pulses start while busy and holds slice_valid
  // high outside FEED.
  task automatic run_job(input int k, input logic acc_in, input int stall_mask, input bit noise);
    int idx, fcyc, cyc, post;
    bit hs;
    j_accepts = 0; j_clears = 0; j_first_clear = 0; j_dones = 0;
    j_ready_cyc = 0; j_drain_cyc = 0; j_l0_valid = 0; j_l0_first = -1; j_l3_first = -1;
    idx = 0; fcyc = 0; cyc = 0; post = 0;
    start = 1'b1; k_len = K_W'(k); accumulate = acc_in;
    @(negedge clk);
    start = 1'b0;
    while (cyc < 600 && post < 3) begin
      if (arr_clear) begin
        j_clears++;
        if (cyc == 0) j_first_clear = 1;
      end
      if (done) j_dones++;
      if (j_dones > 0) post++;
      if (slice_ready) j_ready_cyc++;
      if (state == DRAIN) j_drain_cyc++;
      if (arr_row[0].valid) begin
        j_l0_valid++;
        if (j_l0_first < 0) j_l0_first = cyc;
      end
      if (arr_row[3].valid && j_l3_first < 0) j_l3_first = cyc;
      if (slice_ready) begin
        slice_valid = !((fcyc < 32) && stall_mask[fcyc]);
        fcyc++;
      end else begin
        slice_valid = noise;
      end
      start = (noise && (state == FEED || state == DRAIN)) ? cyc[0] : 1'b0;
      for (int i = 0; i < N; i++) begin
        slice_a[i] = value_t'(a_sl[idx % 16][i]);
        slice_b[i] = value_t'(b_sl[idx % 16][i]);
      end
      hs = slice_valid && slice_ready;
      @(negedge clk);
      if (hs) begin
        j_accepts++;
        idx++;
      end
      cyc++;
    end
    start = 1'b0;
    slice_valid = 1'b0;
  endtask

  // ---------------- directed sequence ----------------
  int rst_dones;

  initial begin
    repeat (3) @(negedge clk);
    check("rst_state", state, IDLE);
    check("rst_busy", busy, 0);
    check("rst_ready", slice_ready, 0);
    check("rst_clear", arr_clear, 0);
    check("rst_done", done, 0);
    check("rst_lanes", (arr_row != '0) || (arr_column != '0), 0);
    rst = 1'b0;

    // 1: reset held three cycles in the middle of FEED.
    set_identity();
    start = 1'b1; k_len = 9'd4; accumulate = 1'b0;
    @(negedge clk);
    start = 1'b0; slice_valid = 1'b1;
    for (int i = 0; i < N; i++) begin
      slice_a[i] = value_t'(a_sl[0][i]);
      slice_b[i] = value_t'(b_sl[0][i]);
    end
    repeat (3) @(negedge clk);
    check("t1_in_feed", state, FEED);
    rst = 1'b1;
    rst_dones = 0;
    repeat (3) begin
      @(negedge clk);
      if (done) rst_dones++;
    end
    check("t1_state", state, IDLE);
    check("t1_busy", busy, 0);
    check("t1_ready", slice_ready, 0);
    check("t1_lanes", (arr_row != '0) || (arr_column != '0), 0);
    rst = 1'b0; slice_valid = 1'b0;
    @(negedge clk);
    if (done) rst_dones++;
    check("t1_no_done", rst_dones, 0);
    check("t1_idle_after", state, IDLE);

    // 2: identity x identity, k_len=4, no stalls.
    set_identity();
    run_job(4, 1'b0, 0, 1'b0);
    check("t2_clear_next", j_first_clear, 1);
    check("t2_clears", j_clears, 1);
    check("t2_accepts", j_accepts, 4);
    check("t2_dones", j_dones, 1);
    check("t2_skew", j_l3_first - j_l0_first, 3);
    check_matrix("t2_c");

    // 3: k_len=3, valid dropped on FEED cycles 2 and 4.
    set_ramp();
    run_job(3, 1'b0, 32'b1010, 1'b0);
    check("t3_accepts", j_accepts, 3);
    check("t3_lane0_valid", j_l0_valid, 3);
    check("t3_dones", j_dones, 1);
    check_matrix("t3_c");
    run_job(3, 1'b0, 0, 1'b0);
    check("t3u_accepts", j_accepts, 3);
    check_matrix("t3u_c");

    // 4: two all-ones jobs, second accumulates onto the first.
    set_ones(2);
    run_job(2, 1'b0, 0, 1'b0);
    check("t4a_clears", j_clears, 1);
    check_matrix("t4a_c");
    set_ones(4);
    run_job(2, 1'b1, 0, 1'b0);
    check("t4b_clears", j_clears, 0);
    check("t4b_accepts", j_accepts, 2);
    check("t4b_dones", j_dones, 1);
    check_matrix("t4b_c");

    // 5: empty job with clear.
    set_ones(0);
    run_job(0, 1'b0, 0, 1'b0);
    check("t5_clears", j_clears, 1);
    check("t5_ready_cyc", j_ready_cyc, 0);
    check("t5_lane0_valid", j_l0_valid, 0);
    check("t5_dones", j_dones, 1);
    check("t5_drain_len", j_drain_cyc >= N + 2, 1);
    check_matrix("t5_c");

    // 6: start pulses while busy and slice_valid outside FEED are ignored.
    set_identity();
    run_job(4, 1'b0, 0, 1'b1);
    check("t6_accepts", j_accepts, 4);
    check("t6_dones", j_dones, 1);
    check("t6_idle", state, IDLE);
    check_matrix("t6_c");

    // Oversized k_len is clamped to K_MAX accepts.
    run_job(300, 1'b0, 0, 1'b0);
    check("clamp_accepts", j_accepts, K_MAX);
    check("clamp_dones", j_dones, 1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
